// File: rtl/prio_pkg.sv
// rtl/prio_pkg.sv - shared types and constants for the priority encoder (optional round-robin: PRIO_RR_EN)
package prio_pkg;

    localparam int DEFAULT_N = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/prio_pick.sv
// rtl/prio_pick.sv - combinational fixed / wrapped round-robin priority scan
module prio_pick
    import prio_pkg::*;
#(
    parameter  int N = DEFAULT_N,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         mode,
    output logic [W-1:0] idx,
    output logic [N-1:0] onehot,
    output logic         any
);

    // Fixed mode: highest set index wins. Round-robin: first set bit at or after ptr, wrapping.
    always_comb begin
        logic found;
        int   pos;
        idx    = '0;
        onehot = '0;
        any    = |req;
        found  = 1'b0;
        pos    = 0;
        if (mode) begin
            for (int k = 0; k < N; k++) begin
                pos = int'(ptr) + k;
                if (pos >= N) begin
                    pos = pos - N;
                end
                if (!found && req[pos]) begin
                    found = 1'b1;
                    idx   = W'(pos);
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    idx = W'(i);
                end
            end
        end
        if (any) begin
            onehot = N'(1) << idx;
        end
    end

endmodule

// File: rtl/prio_encoder_rr.sv
// rtl/prio_encoder_rr.sv - registered priority encoder with valid/ready output; round-robin when PRIO_RR_EN is defined
module prio_encoder_rr
    import prio_pkg::*;
#(
    parameter  int N = DEFAULT_N,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot
);

    state_t       state_q;
    state_t       state_d;
    logic         accept;
    logic         load;
    logic [W-1:0] pick_ptr;
    logic         pick_mode;
    logic [W-1:0] pick_idx;
    logic [N-1:0] pick_onehot;
    logic         pick_any;

    assign out_valid = (state_q == FULL);
    assign accept    = out_valid && out_ready;
    assign load      = pick_any && (!out_valid || accept);

`ifdef PRIO_RR_EN
    logic [W-1:0] ptr;
    logic [W-1:0] ptr_next;

    // On an accepted round-robin result the pointer moves past the winner; the
    // same-edge reload scans from that advanced pointer so back-to-back grants rotate.
    always_comb begin
        ptr_next = ptr;
        if (accept && mode) begin
            ptr_next = (out_idx == W'(N - 1)) ? '0 : out_idx + W'(1);
        end
    end

    // Pointer register, frozen while stalled or in fixed mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_next;
        end
    end

    assign pick_ptr  = ptr_next;
    assign pick_mode = mode;
`else
    assign pick_ptr  = '0;
    assign pick_mode = 1'b0 & mode;
`endif

    prio_pick #(.N(N)) u_pick (
        .req    (req),
        .ptr    (pick_ptr),
        .mode   (pick_mode),
        .idx    (pick_idx),
        .onehot (pick_onehot),
        .any    (pick_any)
    );

    // Output stage next state: fill when a request arrives, drain when accepted with nothing new.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (pick_any) state_d = FULL;
            FULL:    if (accept && !pick_any) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Output stage registers; a held result is never recomputed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            out_idx    <= '0;
            out_onehot <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                out_idx    <= pick_idx;
                out_onehot <= pick_onehot;
            end else if (accept) begin
                out_idx    <= '0;
                out_onehot <= '0;
            end
        end
    end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// tb/tb_prio_encoder_rr.sv - self-checking bench for prio_encoder_rr (both PRIO_RR_EN builds)
module tb_prio_encoder_rr;

    localparam int N = 8;
`ifdef PRIO_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic         mode = 1'b0;
    logic         out_ready = 1'b1;
    logic         out_valid;
    logic [2:0]   out_idx;
    logic [N-1:0] out_onehot;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_valid = 1'b0;
    int m_idx = 0;
    int m_ptr = 0;

    prio_encoder_rr #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .mode       (mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_onehot (out_onehot)
    );

    always #5 clk = ~clk;

    function automatic int winner(input logic [N-1:0] r, input bit rr, input int p);
        if (rr) begin
            for (int k = 0; k < N; k++) begin
                if (r[(p + k) % N]) return (p + k) % N;
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (r[i]) return i;
            end
        end
        return 0;
    endfunction

    // Model: advance one result slot per clock from the visible inputs.
    always @(posedge clk) begin
        bit acc;
        if (rst) begin
            m_valid = 1'b0;
            m_idx   = 0;
            m_ptr   = 0;
        end else begin
            acc = m_valid && out_ready;
            if (acc && RR && mode) m_ptr = (m_idx + 1) % N;
            if (!m_valid || acc) begin
                if (req != 0) begin
                    m_valid = 1'b1;
                    m_idx   = winner(req, RR && mode, m_ptr);
                end else begin
                    m_valid = 1'b0;
                    m_idx   = 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [N-1:0] exp_oh;
        exp_oh = m_valid ? (N'(1) << m_idx) : '0;
        check("model_valid",  32'(out_valid),  32'(m_valid));
        check("model_idx",    32'(out_idx),    32'(m_idx));
        check("model_onehot", 32'(out_onehot), 32'(exp_oh));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input bit v, input int i);
        check({name, "_valid"},  32'(out_valid),  32'(v));
        check({name, "_idx"},    32'(out_idx),    32'(i));
        check({name, "_onehot"}, 32'(out_onehot), v ? 32'(1) << i : 32'd0);
    endtask

    initial begin
        // Reset with requests present: must stay empty.
        rst = 1'b1; req = 8'hFF; mode = 1'b0; out_ready = 1'b1;
        tick(); tick();
        check_out("reset", 1'b0, 0);

        // Fixed priority, latency one.
        rst = 1'b0; req = 8'b0010_1100;
        tick();
        check_out("fixed_2c", 1'b1, 5);

        // Round-robin sweep with all requests.
        req = 8'h00; tick();
        check_out("drain", 1'b0, 0);
        mode = 1'b1; req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            tick();
            check("rr_sweep_idx", 32'(out_idx), RR ? 32'(k % N) : 32'd7);
        end

        // Wrap: leave ptr at 6, then request channels 0 and 1.
        req = 8'h20; tick();
        check_out("rr_pre5", 1'b1, 5);
        req = 8'h00; tick();
        check_out("rr_empty", 1'b0, 0);
        req = 8'b0000_0011; tick();
        check_out("rr_wrap0", 1'b1, RR ? 0 : 1);
        tick();
        check_out("rr_wrap1", 1'b1, 1);

        // Stall: hold idx 3 while req changes.
        mode = 1'b0; req = 8'h08; tick();
        check_out("stall_load", 1'b1, 3);
        out_ready = 1'b0; req = 8'h80;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_out("stall_hold", 1'b1, 3);
        end
        out_ready = 1'b1; tick();
        check_out("stall_release", 1'b1, 7);

        // Reset in the middle of a stall.
        out_ready = 1'b0; req = 8'hFF; tick();
        check_out("stall2_hold", 1'b1, 7);
        rst = 1'b1; tick();
        check_out("rst_midstall", 1'b0, 0);
        rst = 1'b0; req = 8'h00; out_ready = 1'b1;
        tick(); tick();
        check_out("post_rst_idle", 1'b0, 0);
        mode = 1'b1; req = 8'hFF; tick();
        check_out("post_rst_ptr0", 1'b1, RR ? 0 : 7);
        tick();
        check_out("post_rst_next", 1'b1, RR ? 1 : 7);

        req = 8'h00; tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prio_encoder_rr.md
PRIO_ENCODER_RR -- requirements
Module: prio_encoder_rr

Interface
REQ-001 SHALL have parameter N, default 8: number of request channels, legal 2..32.
REQ-002 SHALL have localparam W = clog2(N): index width.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-005 SHALL have port req, input, N: request vector; bit i = channel i requesting.
REQ-006 SHALL have port mode, input, 1: 0 = fixed priority (highest index wins), 1 = round-robin; ignored without PRIO_RR_EN.
REQ-007 SHALL have port out_valid, output, 1: registered result is present.
REQ-008 SHALL have port out_ready, input, 1: consumer accepts result when out_valid && out_ready.
REQ-009 SHALL have port out_idx, output, W: winning channel index.
REQ-010 SHALL have port out_onehot, output, N: one-hot of out_idx; all zero when !out_valid.

Function
REQ-011 SHALL compute winner combinationally from req; SHALL register winner into out_idx/out_onehot, with out_valid set, on the edge after req != 0 when the output stage is empty or being accepted (latency 1 cycle).
REQ-012 SHALL hold out_valid, out_idx and out_onehot stable while out_valid && !out_ready, regardless of req changes.
REQ-013 On accept (out_valid && out_ready), same edge SHALL load the next winner if req != 0, else clear out_valid (full throughput, 1 result/cycle).
REQ-014 Fixed mode: winner SHALL be the highest set index of req.
REQ-015 Round-robin mode: winner SHALL be the first set bit scanning upward from ptr, wrapping N-1 -> 0.
REQ-016 ptr (W bits) SHALL update to (out_idx + 1) mod N only on accept in round-robin mode; ptr SHALL NOT change in fixed mode or while stalled.
REQ-017 req == 0 with stage empty SHALL leave out_valid = 0, out_idx and out_onehot = 0.
REQ-018 A mode change SHALL take effect for the next load; a held result SHALL NOT be recomputed.
REQ-019 Output state SHALL be a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1); EMPTY->FULL on req!=0; FULL->EMPTY on accept with req==0; FULL->FULL otherwise.

Reset
REQ-020 rst SHALL set out_valid=0, out_idx=0, out_onehot=0, ptr=0 on the next edge, overriding any in-flight handshake.
REQ-021 Requests presented during rst high SHALL be ignored; first result may load on the first edge with rst low.

Configuration
REQ-022 With PRIO_RR_EN defined: round-robin logic, ptr register and mode port behaviour SHALL be present per REQ-015/016.
REQ-023 Without PRIO_RR_EN: mode port SHALL remain but be ignored, ptr SHALL not exist, and behaviour SHALL be fixed priority only.

Structure
REQ-024 Shared package prio_pkg SHALL hold the FSM state typedef (EMPTY, FULL) and default N constant.
REQ-025 Sub-module prio_pick SHALL implement the combinational masked/wrapped priority scan (inputs req, ptr, mode; outputs idx, onehot, any).

Verification
REQ-026 N=8, fixed, out_ready=1, req=8'b0010_1100 -> next cycle out_valid=1, out_idx=5, out_onehot=8'b0010_0000.
REQ-027 N=8, RR, ptr=0, out_ready=1, req=8'hFF held 9 cycles -> out_idx sequence 0,1,...,7,0.
REQ-028 Stall: out_ready=0 with result idx=3 held, req changes to 8'h80 for 4 cycles -> out_idx stays 3; raise out_ready -> next result idx=7.
REQ-029 Wrap: RR, ptr=6, req=8'b0000_0011 -> out_idx=0, then ptr=1 -> next out_idx=1.
REQ-030 rst asserted mid-stall with out_valid=1 -> next cycle out_valid=0, out_idx=0, ptr=0; req=0 -> outputs stay zero.
REQ-031 Build without PRIO_RR_EN, mode=1, req=8'hFF -> out_idx=7 every accepted cycle.
